// File: rtl/simple_log_rd_arbiter.sv
// Round-robin arbiter sharing one simple-log read port between NUM_REQ readers,
// with in-order response routing and flush sequencing. Optional stats: SIMPLE_LOG_RD_ARB_STATS_EN.
module simple_log_rd_arbiter #(
    parameter int NUM_REQ            = 2,
    parameter int ADDR_W             = 8,
    parameter int RESP_DATA_STRUCT_W = 64,
    parameter int MAX_OUTST          = 4
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [NUM_REQ-1:0]            req_val,
    input  logic [NUM_REQ*ADDR_W-1:0]     req_addr,
    output logic [NUM_REQ-1:0]            req_rdy,
    output logic                          log_rd_req_val,
    output logic [ADDR_W-1:0]             log_rd_req_addr,
    input  logic                          log_rd_resp_val,
    input  logic [RESP_DATA_STRUCT_W-1:0] log_rd_resp_data,
    output logic [NUM_REQ-1:0]            resp_val,
    output logic [RESP_DATA_STRUCT_W-1:0] resp_data,
    input  logic                          flush_req,
    output logic                          flush_done,
    output logic                          resp_underflow
`ifdef SIMPLE_LOG_RD_ARB_STATS_EN
    ,
    output logic [31:0]                   stat_grants,
    output logic [31:0]                   stat_full_stalls
`endif
);

    localparam int IDW = $clog2(NUM_REQ);
    localparam int PW  = $clog2(MAX_OUTST);
    localparam int CW  = PW + 1;

    typedef enum logic [1:0] {RUN, DRAIN, DONE, HOLD} state_t;

    state_t          state;
    logic [IDW-1:0]  rr_ptr;
    logic [IDW-1:0]  fifo [MAX_OUTST];
    logic [PW-1:0]   wr_ptr;
    logic [PW-1:0]   rd_ptr;
    logic [CW-1:0]   count;
    logic [CW-1:0]   count_next;
    logic [IDW-1:0]  winner;
    logic [IDW-1:0]  head;
    logic            found;
    logic            grant;
    logic            pop;
    logic            full;

    assign full = (count == CW'(MAX_OUTST));
    assign head = fifo[rd_ptr];

    // Grant uses registered count only, so a same-cycle pop never frees a slot early.
    always_comb begin
        logic [IDW-1:0] cand;
        found  = 1'b0;
        winner = '0;
        for (int unsigned k = 1; k <= NUM_REQ; k++) begin
            cand = IDW'((32'(rr_ptr) + k) % NUM_REQ);
            if (!found && req_val[cand]) begin
                found  = 1'b1;
                winner = cand;
            end
        end
        grant   = !rst && (state == RUN) && !flush_req && !full && found;
        req_rdy = '0;
        if (grant) req_rdy[winner] = 1'b1;
        log_rd_req_val  = grant;
        log_rd_req_addr = req_addr[32'(winner)*ADDR_W +: ADDR_W];
    end

    always_comb begin
        pop      = !rst && log_rd_resp_val && (count != '0);
        resp_val = '0;
        if (pop) resp_val[head] = 1'b1;
        resp_data = log_rd_resp_data;
        count_next = count;
        if (grant && !pop) count_next = count + 1'b1;
        else if (!grant && pop) count_next = count - 1'b1;
    end

    always_ff @(posedge clk) begin
        if (grant) fifo[wr_ptr] <= winner;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state          <= RUN;
            rr_ptr         <= IDW'(NUM_REQ - 1);
            wr_ptr         <= '0;
            rd_ptr         <= '0;
            count          <= '0;
            flush_done     <= 1'b0;
            resp_underflow <= 1'b0;
        end else begin
            count <= count_next;
            if (grant) begin
                rr_ptr <= winner;
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) rd_ptr <= rd_ptr + 1'b1;
            if (log_rd_resp_val && (count == '0)) resp_underflow <= 1'b1;

            flush_done <= 1'b0;
            case (state)
                RUN:   if (flush_req) state <= DRAIN;
                DRAIN: if (count_next == '0) begin
                    state      <= DONE;
                    flush_done <= 1'b1;
                end
                DONE:  state <= flush_req ? HOLD : RUN;
                HOLD:  if (!flush_req) state <= RUN;
                default: state <= RUN;
            endcase
        end
    end

`ifdef SIMPLE_LOG_RD_ARB_STATS_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stat_grants      <= '0;
            stat_full_stalls <= '0;
        end else begin
            if (grant && (stat_grants != '1)) stat_grants <= stat_grants + 1'b1;
            if ((|req_val) && full && (state == RUN) && (stat_full_stalls != '1))
                stat_full_stalls <= stat_full_stalls + 1'b1;
        end
    end
`endif

endmodule
